// File: rtl/sd_spi_arbiter.sv
// Two-requester SD card SPI arbiter with a shared byte-shift engine and pending-transfer timeout.
// Build option SD_SPI_FASTCLK_EN: SCK edges on ck14 (7 MHz SCK) instead of ck7 (3.5 MHz SCK).
module sd_spi_arbiter #(
  parameter int unsigned TIMEOUT_W = 12
) (
  input  logic       clk28,
  input  logic       rst_n,
  input  logic       ck14,
  input  logic       ck7,
  input  logic       r0_cs_n,
  input  logic       r0_start,
  input  logic [7:0] r0_din,
  output logic [7:0] r0_dout,
  output logic       r0_busy,
  input  logic       r1_cs_n,
  input  logic       r1_start,
  input  logic [7:0] r1_din,
  output logic [7:0] r1_dout,
  output logic       r1_busy,
  output logic [1:0] drop,
  input  logic [1:0] drop_clr,
  output logic       owner,
  output logic       granted,
  input  logic       sd_miso,
  output logic       sd_mosi,
  output logic       sd_sck,
  output logic       sd_cs
);
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned EDGE_W = 4;
  localparam logic [TIMEOUT_W-1:0] TMO_MAX = '1;

  typedef enum logic {FREE = 1'b0, OWNED = 1'b1} state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d, last_owner_q, last_owner_d;
  logic                   active_q, active_d;
  logic [EDGE_W-1:0]      edge_q, edge_d;
  logic [BYTE_W-1:0]      shift_q, shift_d;
  logic                   rx_q, rx_d;
  logic [1:0]             pend_q, pend_d;
  logic [1:0][BYTE_W-1:0] pdin_q, pdin_d;
  logic [TIMEOUT_W-1:0]   tmo_q, tmo_d;
  logic [1:0][BYTE_W-1:0] dout_q, dout_d;
  logic [1:0]             busy_q, busy_d, drop_q, drop_d;
  logic                   sck_q, sck_d, mosi_q, mosi_d, cs_q, cs_d;

  logic                   sck_stb;
  logic [1:0]             cs_n, start, req;
  logic [1:0][BYTE_W-1:0] din;
  logic                   launch;
  logic [BYTE_W-1:0]      launch_din;

`ifdef SD_SPI_FASTCLK_EN
  assign sck_stb = ck14;
`else
  // ck7 always coincides with ck14, so this is simply the ck7 rate
  assign sck_stb = ck7 & ck14;
`endif

  assign cs_n  = {r1_cs_n, r0_cs_n};
  assign start = {r1_start, r0_start};
  assign din   = {r1_din, r0_din};

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    active_d     = active_q;
    edge_d       = edge_q;
    shift_d      = shift_q;
    rx_d         = rx_q;
    pend_d       = pend_q;
    pdin_d       = pdin_q;
    tmo_d        = tmo_q;
    dout_d       = dout_q;
    drop_d       = drop_q & ~drop_clr;
    sck_d        = sck_q;
    launch       = 1'b0;
    launch_din   = shift_q;
    req          = ~cs_n | start | pend_q;

    // a waiting non-owner is dropped once the ck7 timeout saturates
    if (|pend_q) begin
      if (tmo_q == TMO_MAX) begin
        for (int i = 0; i < 2; i++) begin
          if (pend_q[i] && !(state_q == OWNED && owner_q == 1'(i))) begin
            pend_d[i] = 1'b0;
            dout_d[i] = '1;
            drop_d[i] = 1'b1;
          end
        end
      end else if (ck7) begin
        tmo_d = tmo_q + TIMEOUT_W'(1);
      end
    end

    if (state_q == OWNED && !active_q) begin
      if (pend_q[owner_q]) begin
        launch          = 1'b1;
        launch_din      = pdin_q[owner_q];
        pend_d[owner_q] = 1'b0;
      end else if (start[owner_q]) begin
        launch     = 1'b1;
        launch_din = din[owner_q];
      end
    end

    for (int i = 0; i < 2; i++) begin
      if (start[i] && !(state_q == OWNED && owner_q == 1'(i)) && !pend_q[i]) begin
        pend_d[i] = 1'b1;
        pdin_d[i] = din[i];
        tmo_d     = '0;
      end
    end

    // shift engine: odd edges rise and sample, even edges fall and shift
    if (launch) begin
      active_d = 1'b1;
      edge_d   = '0;
      shift_d  = launch_din;
      sck_d    = 1'b0;
    end else if (active_q && sck_stb) begin
      edge_d = edge_q + EDGE_W'(1);
      if (!edge_q[0]) begin
        sck_d = 1'b1;
        rx_d  = sd_miso;
      end else begin
        sck_d   = 1'b0;
        shift_d = {shift_q[BYTE_W-2:0], rx_q};
        if (edge_q == '1) begin
          active_d        = 1'b0;
          dout_d[owner_q] = {shift_q[BYTE_W-2:0], rx_q};
        end
      end
    end

    case (state_q)
      FREE: begin
        if (|req) begin
          state_d = OWNED;
          if (&req)        owner_d = ~last_owner_q;
          else if (req[0]) owner_d = 1'b0;
          else             owner_d = 1'b1;
        end
      end
      OWNED: begin
        if (cs_n[owner_q] && !active_q && !start[owner_q] && !pend_q[owner_q]) begin
          state_d      = FREE;
          last_owner_d = owner_q;
        end
      end
      default: state_d = FREE;
    endcase

    cs_d   = (state_d != OWNED);
    mosi_d = active_d ? shift_d[BYTE_W-1] : 1'b1;
    for (int i = 0; i < 2; i++) begin
      busy_d[i] = pend_d[i] | ((active_q | active_d) && owner_d == 1'(i));
    end
  end

  always_ff @(posedge clk28 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= FREE;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      active_q     <= 1'b0;
      edge_q       <= '0;
      shift_q      <= '1;
      rx_q         <= 1'b0;
      pend_q       <= '0;
      pdin_q       <= '0;
      tmo_q        <= '0;
      dout_q       <= '1;
      busy_q       <= '0;
      drop_q       <= '0;
      sck_q        <= 1'b0;
      mosi_q       <= 1'b1;
      cs_q         <= 1'b1;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      active_q     <= active_d;
      edge_q       <= edge_d;
      shift_q      <= shift_d;
      rx_q         <= rx_d;
      pend_q       <= pend_d;
      pdin_q       <= pdin_d;
      tmo_q        <= tmo_d;
      dout_q       <= dout_d;
      busy_q       <= busy_d;
      drop_q       <= drop_d;
      sck_q        <= sck_d;
      mosi_q       <= mosi_d;
      cs_q         <= cs_d;
    end
  end

  assign r0_dout = dout_q[0];
  assign r1_dout = dout_q[1];
  assign r0_busy = busy_q[0];
  assign r1_busy = busy_q[1];
  assign drop    = drop_q;
  assign owner   = owner_q;
  assign granted = (state_q == OWNED);
  assign sd_sck  = sck_q;
  assign sd_mosi = mosi_q;
  assign sd_cs   = cs_q;

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Directed self-checking bench for sd_spi_arbiter (honours SD_SPI_FASTCLK_EN).
module tb_sd_spi_arbiter;
`ifdef SD_SPI_FASTCLK_EN
  localparam int XFER_CYC = 34;
`else
  localparam int XFER_CYC = 66;
`endif

  logic clk28 = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] div = 2'd0;
  logic ck14, ck7;
  logic r0_cs_n = 1'b1, r0_start = 1'b0, r1_cs_n = 1'b1, r1_start = 1'b0;
  logic [7:0] r0_din = 8'h00, r1_din = 8'h00;
  logic [7:0] r0_dout, r1_dout;
  logic r0_busy, r1_busy, owner, granted, sd_mosi, sd_sck, sd_cs;
  logic [1:0] drop;
  logic [1:0] drop_clr = 2'b00;
  logic sd_miso = 1'b1;

  int checks = 0;
  int errors = 0;
  logic [7:0] mosi_b;
  int cycles, ticks, sck_hi, guard;
  logic cs16;

  always #18 clk28 = ~clk28;
  always @(posedge clk28) div <= div + 2'd1;
  assign ck14 = div[0];
  assign ck7  = &div;

  sd_spi_arbiter #(.TIMEOUT_W(12)) dut (
    .clk28(clk28), .rst_n(rst_n), .ck14(ck14), .ck7(ck7),
    .r0_cs_n(r0_cs_n), .r0_start(r0_start), .r0_din(r0_din), .r0_dout(r0_dout), .r0_busy(r0_busy),
    .r1_cs_n(r1_cs_n), .r1_start(r1_start), .r1_din(r1_din), .r1_dout(r1_dout), .r1_busy(r1_busy),
    .drop(drop), .drop_clr(drop_clr), .owner(owner), .granted(granted),
    .sd_miso(sd_miso), .sd_mosi(sd_mosi), .sd_sck(sd_sck), .sd_cs(sd_cs)
  );

  task automatic step(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk28);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic busy_of(input int req);
    return (req == 0) ? r0_busy : r1_busy;
  endfunction

  // optionally starts a byte, then plays the card (MSB-first echo) until busy drops
  task automatic xfer(input int req, input bit do_start, input logic [7:0] din,
                      input logic [7:0] echo, input int rel_edge, input int stop_edge,
                      output logic [7:0] mosi_o, output int cyc, output logic cs_o);
    int idx, edges, g;
    logic prev;
    idx = 0; edges = 0; g = 0; cyc = 0; mosi_o = 8'h00; cs_o = 1'b1;
    sd_miso = echo[7];
    if (do_start) begin
      while (ck7 !== 1'b1 && g < 16) begin step(); g++; end
      if (req == 0) begin r0_din = din; r0_start = 1'b1; end
      else begin r1_din = din; r1_start = 1'b1; end
      step();
      cyc = 1;
      r0_start = 1'b0;
      r1_start = 1'b0;
    end
    prev = sd_sck;
    while (busy_of(req) && cyc < 400) begin
      step();
      cyc++;
      if (sd_sck !== prev) begin
        edges++;
        if (sd_sck) mosi_o = {mosi_o[6:0], sd_mosi};
        else begin
          idx++;
          if (idx < 8) sd_miso = echo[7-idx];
        end
        if (edges == 16) cs_o = sd_cs;
        if (edges == rel_edge) begin
          if (req == 0) r0_cs_n = 1'b1; else r1_cs_n = 1'b1;
        end
        if (edges == stop_edge) return;
      end
      prev = sd_sck;
    end
  endtask

  initial begin
    step(3);
    rst_n = 1'b1;
    step(2);
    chk("rst_sd_cs", sd_cs, 1);
    chk("rst_sd_sck", sd_sck, 0);
    chk("rst_sd_mosi", sd_mosi, 1);
    chk("rst_r0_dout", r0_dout, 8'hFF);
    chk("rst_r1_dout", r1_dout, 8'hFF);
    chk("rst_busy", {r1_busy, r0_busy}, 0);
    chk("rst_drop", drop, 0);
    chk("rst_grant", {granted, owner}, 0);

    // tie straight after reset goes to r0, release hands over to r1
    r0_cs_n = 1'b0; r1_cs_n = 1'b0;
    step(2);
    chk("tie0_grant", {granted, owner}, 2'b10);
    chk("tie0_cs", sd_cs, 0);
    r0_cs_n = 1'b1;
    step(3);
    chk("handover_owner", {granted, owner}, 2'b11);
    chk("handover_cs", sd_cs, 0);
    r1_cs_n = 1'b1;
    step(3);
    chk("free_grant", granted, 0);
    chk("free_cs", sd_cs, 1);

    // basic byte A5 out, 3C in
    r0_cs_n = 1'b0;
    step(2);
    chk("t1_owner", {granted, owner}, 2'b10);
    xfer(0, 1'b1, 8'hA5, 8'h3C, 0, 0, mosi_b, cycles, cs16);
    chk("t1_mosi", mosi_b, 8'hA5);
    chk("t1_r0_dout", r0_dout, 8'h3C);
    chk("t1_busy_cycles", cycles, XFER_CYC);
    chk("t1_cs_during", cs16, 0);
    chk("t1_r1_dout", r1_dout, 8'hFF);
    r0_cs_n = 1'b1;
    step(3);

    // r0 owned last, so the next tie goes to r1
    r0_cs_n = 1'b0; r1_cs_n = 1'b0;
    step(2);
    chk("tie1_grant", {granted, owner}, 2'b11);
    r0_cs_n = 1'b1; r1_cs_n = 1'b1;
    step(3);

    // non-owner start queues and runs once the owner releases
    r0_cs_n = 1'b0;
    step(2);
    r1_din = 8'hFF; r1_start = 1'b1;
    step();
    r1_start = 1'b0;
    chk("t3_r1_busy", r1_busy, 1);
    sck_hi = 0;
    for (int k = 0; k < 20; k++) begin
      step();
      if (sd_sck) sck_hi++;
    end
    chk("t3_no_sck", sck_hi, 0);
    chk("t3_still_r0", {granted, owner, r1_busy}, 3'b101);
    r0_cs_n = 1'b1;
    xfer(1, 1'b0, 8'h00, 8'h96, 0, 0, mosi_b, cycles, cs16);
    chk("t3_done", (cycles < 400), 1);
    chk("t3_mosi", mosi_b, 8'hFF);
    chk("t3_r1_dout", r1_dout, 8'h96);
    chk("t3_r0_busy", r0_busy, 0);
    step(2);
    chk("t3_free", granted, 0);

    // timeout drop while drop_clr is held: the drop wins, then clears
    r0_cs_n = 1'b0;
    step(2);
    drop_clr = 2'b10;
    r1_din = 8'h12; r1_start = 1'b1;
    step();
    r1_start = 1'b0;
    ticks = 0; guard = 0;
    while (r1_busy && guard < 20000) begin
      if (ck7) ticks++;
      step();
      guard++;
    end
    chk("t4_ticks", ticks, 4095);
    chk("t4_drop_set", drop, 2'b10);
    chk("t4_r1_dout", r1_dout, 8'hFF);
    chk("t4_r0_busy", r0_busy, 0);
    step();
    chk("t4_drop_clr", drop, 2'b00);
    drop_clr = 2'b00;

    // owner cs_n rises at edge 7; sd_cs held until the byte completes
    xfer(0, 1'b1, 8'h5A, 8'hC3, 7, 0, mosi_b, cycles, cs16);
    chk("t5_cs_at16", cs16, 0);
    chk("t5_mosi", mosi_b, 8'h5A);
    chk("t5_r0_dout", r0_dout, 8'hC3);
    chk("t5_cycles", cycles, XFER_CYC);
    chk("t5_cs_after", {sd_cs, granted}, 2'b10);

    // async reset at edge 9
    r0_cs_n = 1'b0;
    step(2);
    xfer(0, 1'b1, 8'h0F, 8'hF0, 0, 9, mosi_b, cycles, cs16);
    chk("t6_sck_before", sd_sck, 1);
    rst_n = 1'b0;
    #1;
    chk("t6_sck", sd_sck, 0);
    chk("t6_cs", sd_cs, 1);
    chk("t6_busy", r0_busy, 0);
    chk("t6_dout", r0_dout, 8'hFF);
    chk("t6_mosi_grant", {sd_mosi, granted}, 2'b10);
    r0_cs_n = 1'b1;
    #5;
    rst_n = 1'b1;
    step(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sd_spi_arbiter.md
Name: sd_spi_arbiter

Overview:
- Shares the single SD card SPI port between two requesters: requester 0 (DivMMC, ports E7/EB) and requester 1 (Z-Controller, ports 77/57).
- Contains the one SPI byte-shift engine and decides which requester owns sd_cs.
- Queues one transfer from the non-owning requester and drops it with a timeout if the bus never frees.
- Sits between both port decoders and the SD pins at top level.

Parameters:
TIMEOUT_W, 12, width of pending-transfer timeout counter in ck7 ticks; timeout = 2^TIMEOUT_W-1 ticks

Ports:
clk28  in  1  system clock, 28 MHz
rst_n  in  1  asynchronous active-low reset
ck14  in  1  clk28-synchronous strobe, 14 MHz rate
ck7  in  1  clk28-synchronous strobe, 7 MHz rate, coincident with every other ck14
r0_cs_n  in  1  requester 0 chip-select request, active low
r0_start  in  1  requester 0 one-clk28 transfer strobe
r0_din  in  8  requester 0 byte to send; sampled on r0_start
r0_dout  out  8  requester 0 last received byte
r0_busy  out  1  requester 0 transfer pending/active; drives cpuwait
r1_cs_n, r1_start, r1_din, r1_dout, r1_busy  same as r0_*, for requester 1
drop  out  2  sticky per-requester "pending transfer dropped" flags
drop_clr  in  2  clears the matching drop bit
owner  out  1  current owner index; valid when granted=1
granted  out  1  bus owned
sd_miso  in  1  card data out
sd_mosi  out  1  card data in
sd_sck  out  1  SPI clock, mode 0
sd_cs  out  1  card select, active low

Behaviour:
- Reset values: sd_cs=1, sd_sck=0, sd_mosi=1, r0_dout=r1_dout=FF, busy=0, drop=0, granted=0, owner=0, all pending flags 0.
- Arbitration FSM states:
  - FREE: no owner. A requester with cs_n=0 or start=1 is granted the next clk28. If both qualify in the same cycle, the one that is not last_owner wins; last_owner resets to 1, so r0 wins first.
  - OWNED: sd_cs = ~owner's cs_n, registered.
  - OWNED -> FREE when the owner's cs_n=1 and the engine is idle and no owner start is latched. last_owner is updated on this transition.
- Start handling:
  - Owner start: byte latched, busy=1 on the next clk28, transfer begins.
  - Owner start while its own transfer is active: the new start is ignored and busy stays 1.
  - Non-owner start: pending bit set, busy=1, timeout counter cleared.
  - Pending requester gets the grant on the FREE transition and its transfer begins automatically.
  - If the timeout counter saturates first (counts ck7 ticks): pending cleared, busy=0, dout=FF, drop bit set.
- SPI engine:
  - An sck edge occurs on every sck-strobe while active. The sck-strobe is ck7 by default.
  - 16 edges per byte. Odd edges raise sck and sample sd_miso into the shift register LSB. Even edges lower sck and shift, so MSB goes out on sd_mosi.
  - sd_mosi = shift[7] while active, else 1.
  - On the 16th edge: dout of the active requester <= shift register, engine idle, busy=0 on the following clk28.
  - Latency from start to busy falling = 16 strobes + 2 clk28.
- Simultaneous events:
  - drop_clr and a new drop in the same cycle: the drop wins, bit stays 1.
  - Owner cs_n rising mid-byte: the byte completes and sd_cs rises only after completion.
  - Non-owner cs_n alone never changes sd_cs.
- Reset mid-transfer: all state returns to reset values immediately (async); no partial dout update.

Optional Feature:
SD_SPI_FASTCLK_EN:
- Defined: sck-strobe = ck14. Byte time 16 ck14 strobes, 7 MHz SCK.
- Undefined: sck-strobe = ck7, 3.5 MHz SCK. This is the safe default for marginal cards.
- Arbitration and timeout timing are unchanged in both cases; timeout always counts ck7.

Test Plan:
- Reset, then r0_cs_n=0 and r0_start with din=A5, card echoes 3C: sd_mosi shows bits 1,0,1,0,0,1,0,1 on falling edges; r0_dout=3C; sd_cs=0; busy high for 16 strobes + 2 clk.
- r0 and r1 both assert cs_n=0 in the same clk28 after reset: owner=0. r0 releases: owner becomes 1. Both request again: owner=1 is granted only if r0 is idle, otherwise r0 loses next tie.
- r0 owns; r1_start din=FF: r1_busy=1 and no sck activity for r1. r0 sets cs_n=1: r1 is granted and its byte transfers; r1_busy falls afterward.
- r0 holds cs_n=0 indefinitely; r1_start: after 2^12-1 ck7 ticks r1_busy=0, r1_dout=FF, drop=2'b10. drop_clr=2'b10 clears it.
- r0_cs_n rises at edge 7 of a transfer: sd_cs stays 0 until edge 16, then rises; r0_dout valid.
- rst_n pulsed low at edge 9: sd_sck=0, sd_cs=1, busy=0, dout=FF immediately. With SD_SPI_FASTCLK_EN, repeat the first test: byte completes in half the clk28 cycles.
